// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// retry counter width and a constant-evaluable clog2.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT = 3'd0,
    ST_WAIT   = 3'd1,
    ST_GAP    = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam int RETRY_W = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/reset_sequencer_term.sv
// Cycle counter with synchronous clear/enable and a terminal flag that is
// high while the count equals limit-1.
module rs_term_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         term_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == (limit - W'(1)));

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in order, waiting for each stage's ready
// plus a settle gap; timeouts retry the whole sequence, then latch a fault.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int HOLD       = 16,
  parameter int GAP        = 8,
  parameter int TIMEOUT    = 1024,
  parameter int MAX_RETRY  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  async_reset_i,
  input  logic                  reset_i,
  input  logic [NUM_STAGES-1:0] ready_i,
  output logic [NUM_STAGES-1:0] rst_o,
  output logic                  done_o,
  output logic                  fault_o,
  output logic [RETRY_W-1:0]    retry_count_o,
  output logic [3:0]            stage_o,
  output state_t                dbg_state_o
);

  localparam int IDX_W = (clog2(NUM_STAGES) < 1) ? 1 : clog2(NUM_STAGES);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;

  logic                  cnt_clr;
  logic                  cnt_en;
  logic                  cnt_term;
  logic [CNT_WIDTH-1:0]  cnt_limit;
  logic                  lost;

  // One counter serves every timed state; clearing on any state change (or
  // restart request) keeps it from carrying a stale count into the next state.
  always_comb begin
    cnt_limit = CNT_WIDTH'(TIMEOUT);
    case (state_q)
      ST_ASSERT: cnt_limit = CNT_WIDTH'(HOLD);
      ST_GAP:    cnt_limit = CNT_WIDTH'(GAP);
      default:   cnt_limit = CNT_WIDTH'(TIMEOUT);
    endcase
  end

  assign cnt_clr = reset_i || (state_d != state_q);
  assign cnt_en  = (state_q == ST_ASSERT) || (state_q == ST_WAIT) || (state_q == ST_GAP);

  rs_term_counter #(
    .W (CNT_WIDTH)
  ) u_term_counter (
    .clk    (clk),
    .rst    (async_reset_i),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .limit  (cnt_limit),
    .term_o (cnt_term)
  );

  always_comb begin
    lost = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if ((k <= int'(idx_q)) && !ready_i[k]) lost = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge async_reset_i) begin
    if (async_reset_i) begin
      state_q <= ST_ASSERT;
      idx_q   <= '0;
      retry_q <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  // Next state; reset_i overrides every other event in the same cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    if (reset_i) begin
      state_d = ST_ASSERT;
      idx_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_term) begin
            state_d = ST_WAIT;
            idx_d   = '0;
          end
        end
        ST_WAIT: begin
          if (ready_i[idx_q]) begin
            state_d = ST_GAP;
          end else if (cnt_term) begin
            retry_d = (retry_q == RETRY_W'(MAX_RETRY)) ? retry_q : retry_q + RETRY_W'(1);
            if (retry_d == RETRY_W'(MAX_RETRY)) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_ASSERT;
              idx_d   = '0;
            end
          end
        end
        ST_GAP: begin
          if (lost) begin
            state_d = ST_ASSERT;
            idx_d   = '0;
          end else if (cnt_term) begin
            if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_WAIT;
              idx_d   = idx_q + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (lost) begin
            state_d = ST_ASSERT;
            idx_d   = '0;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default: begin
          state_d = ST_ASSERT;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they move with the state
  always_comb begin
    rst_d   = '1;
    done_d  = (state_d == ST_DONE);
    fault_d = (state_d == ST_FAULT);
    if ((state_d == ST_WAIT) || (state_d == ST_GAP) || (state_d == ST_DONE)) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        rst_d[k] = (k > int'(idx_d));
      end
    end
  end

  assign rst_o         = rst_q;
  assign done_o        = done_q;
  assign fault_o       = fault_q;
  assign retry_count_o = retry_q;
  assign stage_o       = 4'(idx_q);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: constant vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam int NS     = 3;
  localparam int HOLD_C = 4;
  localparam int GAP_C  = 2;
  localparam int TO_C   = 8;
  localparam int MR     = 2;

  logic          clk = 1'b0;
  logic          async_reset_i;
  logic          reset_i;
  logic [NS-1:0] ready_i;
  logic [NS-1:0] rst_o;
  logic          done_o;
  logic          fault_o;
  logic [7:0]    retry_count_o;
  logic [3:0]    stage_o;
  state_t        dbg_state;

  reset_sequencer #(
    .NUM_STAGES (NS),
    .HOLD       (HOLD_C),
    .GAP        (GAP_C),
    .TIMEOUT    (TO_C),
    .MAX_RETRY  (MR),
    .CNT_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .async_reset_i (async_reset_i),
    .reset_i       (reset_i),
    .ready_i       (ready_i),
    .rst_o         (rst_o),
    .done_o        (done_o),
    .fault_o       (fault_o),
    .retry_count_o (retry_count_o),
    .stage_o       (stage_o),
    .dbg_state_o   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: phase 0 hold, 1 waiting for ready, 2 settling,
  // 3 all released, 4 fault. m_rel = number of domains currently released.
  int m_phase, m_age, m_rel, m_retry;

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_rel = 0; m_retry = 0;
  endtask

  task automatic model_restart();
    m_phase = 0; m_age = 0; m_rel = 0;
  endtask

  task automatic model_step(input logic rq, input logic [NS-1:0] rdy);
    bit lost;
    lost = 0;
    for (int k = 0; k < m_rel; k++) if (!rdy[k]) lost = 1;
    if (rq) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (m_age + 1 == HOLD_C) begin m_phase = 1; m_age = 0; m_rel = 1; end
           else m_age++;
        1: if (rdy[m_rel-1]) begin m_phase = 2; m_age = 0; end
           else if (m_age + 1 == TO_C) begin
             m_retry = (m_retry + 1 > MR) ? MR : m_retry + 1;
             if (m_retry == MR) m_phase = 4;
             else model_restart();
           end else m_age++;
        2: if (lost) model_restart();
           else if (m_age + 1 == GAP_C) begin
             if (m_rel == NS) m_phase = 3;
             else begin m_rel++; m_phase = 1; m_age = 0; end
           end else m_age++;
        3: if (lost) model_restart();
        default: ;
      endcase
    end
  endtask

  task automatic compare_model();
    logic [NS-1:0] ones;
    logic [NS-1:0] e_rst;
    ones  = '1;
    e_rst = (m_phase == 0 || m_phase == 4) ? ones : NS'(ones << m_rel);
    check("m_rst",   rst_o, e_rst);
    check("m_done",  done_o, (m_phase == 3));
    check("m_fault", fault_o, (m_phase == 4));
    check("m_retry", retry_count_o, m_retry);
    check("m_stage", stage_o, (m_rel == 0) ? 0 : m_rel - 1);
  endtask

  // Driver tasks: tick advances one edge and checks against the model
  task automatic tick();
    @(posedge clk);
    model_step(reset_i, ready_i);
    #1;
    compare_model();
  endtask

  // Called at posedge+1; pulse lies wholly between two edges
  task automatic async_pulse(input string tag);
    #2 async_reset_i = 1'b1;
    #1;
    model_reset();
    check({tag, "_rst"},   rst_o, 3'b111);
    check({tag, "_done"},  done_o, 0);
    check({tag, "_fault"}, fault_o, 0);
    check({tag, "_retry"}, retry_count_o, 0);
    check({tag, "_stage"}, stage_o, 0);
    #2 async_reset_i = 1'b0;
  endtask

  typedef struct {
    logic          rq;
    logic [NS-1:0] rdy;
    logic [NS-1:0] rst;
    logic          done;
    logic [3:0]    stage;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int hold_left;

    tbl[0]  = '{1'b0, 3'b111, 3'b111, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 3'b111, 3'b111, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 3'b111, 3'b111, 1'b0, 4'd0};
    tbl[3]  = '{1'b0, 3'b111, 3'b110, 1'b0, 4'd0};
    tbl[4]  = '{1'b0, 3'b111, 3'b110, 1'b0, 4'd0};
    tbl[5]  = '{1'b0, 3'b111, 3'b110, 1'b0, 4'd0};
    tbl[6]  = '{1'b0, 3'b111, 3'b100, 1'b0, 4'd1};
    tbl[7]  = '{1'b0, 3'b111, 3'b100, 1'b0, 4'd1};
    tbl[8]  = '{1'b0, 3'b111, 3'b100, 1'b0, 4'd1};
    tbl[9]  = '{1'b0, 3'b111, 3'b000, 1'b0, 4'd2};
    tbl[10] = '{1'b0, 3'b111, 3'b000, 1'b0, 4'd2};
    tbl[11] = '{1'b0, 3'b111, 3'b000, 1'b0, 4'd2};
    tbl[12] = '{1'b0, 3'b111, 3'b000, 1'b1, 4'd2};

    async_reset_i = 1'b1;
    reset_i       = 1'b0;
    ready_i       = '1;
    model_reset();
    #6;
    check("init_rst",   rst_o, 3'b111);
    check("init_done",  done_o, 0);
    check("init_fault", fault_o, 0);
    check("init_retry", retry_count_o, 0);
    check("init_stage", stage_o, 0);
    async_reset_i = 1'b0;

    // In-order release with every stage ready
    for (int i = 0; i < 13; i++) begin
      reset_i = tbl[i].rq;
      ready_i = tbl[i].rdy;
      tick();
      check($sformatf("t1_rst_e%0d", i + 1),   rst_o, tbl[i].rst);
      check($sformatf("t1_done_e%0d", i + 1),  done_o, tbl[i].done);
      check($sformatf("t1_stage_e%0d", i + 1), stage_o, tbl[i].stage);
    end

    // Stage 1 never ready: two timeouts then fault, cleared by reset_i
    async_pulse("t2_pre");
    ready_i = 3'b101;
    repeat (15) tick();
    check("t2_retry1", retry_count_o, 1);
    check("t2_rst1",   rst_o, 3'b111);
    check("t2_fault1", fault_o, 0);
    repeat (15) tick();
    check("t2_fault", fault_o, 1);
    check("t2_rstf",  rst_o, 3'b111);
    check("t2_retry2", retry_count_o, 2);
    repeat (100) tick();
    check("t2_fault_held", fault_o, 1);
    check("t2_rst_held",   rst_o, 3'b111);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("t2_clr_fault", fault_o, 0);
    check("t2_clr_retry", retry_count_o, 0);
    check("t2_clr_rst",   rst_o, 3'b111);
    ready_i = '1;

    // reset_i held 3 cycles during stage-1 gap
    async_pulse("t3_pre");
    repeat (8) tick();
    check("t3_stage", stage_o, 1);
    reset_i = 1'b1;
    tick();
    check("t3_rst_on",  rst_o, 3'b111);
    check("t3_done_on", done_o, 0);
    repeat (2) tick();
    reset_i = 1'b0;
    repeat (3) tick();
    check("t3_rst_hold", rst_o, 3'b111);
    tick();
    check("t3_rst_rel", rst_o, 3'b110);

    // Lost ready in DONE
    async_pulse("t4_pre");
    repeat (13) tick();
    check("t4_done", done_o, 1);
    ready_i = 3'b110;
    tick();
    ready_i = 3'b111;
    check("t4_rst_lost",  rst_o, 3'b111);
    check("t4_done_lost", done_o, 0);
    check("t4_retry",     retry_count_o, 0);
    repeat (12) tick();
    check("t4_done_early", done_o, 0);
    tick();
    check("t4_done_back", done_o, 1);

    // reset_i coincident with a timeout terminal count
    async_pulse("t5_pre");
    ready_i = 3'b101;
    repeat (14) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("t5_retry", retry_count_o, 0);
    check("t5_fault", fault_o, 0);
    check("t5_rst",   rst_o, 3'b111);
    repeat (29) tick();
    check("t5b_retry_pre", retry_count_o, 1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("t5b_fault", fault_o, 0);
    check("t5b_retry", retry_count_o, 0);

    // Async reset mid-WAIT and in FAULT
    async_pulse("t6_pre");
    repeat (8) tick();
    check("t6_wait_stage", stage_o, 1);
    check("t6_wait_rst",   rst_o, 3'b100);
    async_pulse("t6_wait");
    repeat (30) tick();
    check("t6_fault", fault_o, 1);
    async_pulse("t6_fault");
    ready_i = '1;

    // Randomized traffic against the model
    hold_left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold_left == 0) begin
        hold_left = $urandom_range(1, 20);
        if ($urandom_range(0, 9) < 7) ready_i = '1;
        else ready_i = NS'($urandom_range(0, 7));
      end
      hold_left--;
      reset_i = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Consumes the synchronous reset pulse produced by the board reset generator and releases a set of downstream reset domains in a fixed order.
- Each stage's reset is deasserted only after the previous stage has reported ready (e.g. MMCM lock, PHY calibration done) plus a settle gap.
- A stage that never reports ready times out and triggers a bounded number of full retries, then a latched fault.
- Sits between the reset pulse generator and the per-core resets of the ROACH2 design.

Parameters:
NUM_STAGES, 4, number of sequenced reset domains (1..16)
HOLD, 16, cycles all resets are held after request before the first release (>=1)
GAP, 8, settle cycles after a stage reports ready before the next release (>=1)
TIMEOUT, 1024, max cycles to wait for ready_i of the current stage (>=1)
MAX_RETRY, 3, timeouts tolerated before entering FAULT (>=1, <=255)
CNT_WIDTH, 16, internal counter width; must hold max(HOLD, GAP, TIMEOUT)

Ports:
clk  in  1  system clock; all logic on the rising edge
async_reset_i  in  1  asynchronous, active-high reset
reset_i  in  1  synchronous sequence-restart request (reset pulse from upstream generator)
ready_i  in  NUM_STAGES  per-stage ready; already synchronous to clk
rst_o  out  NUM_STAGES  per-stage active-high reset, registered
done_o  out  1  all stages released and ready
fault_o  out  1  retries exhausted; sticky until reset_i
retry_count_o  out  8  timeouts since last reset_i/async reset
stage_o  out  4  index of the stage currently being released/waited on

Behaviour:
- Async reset values:
  - state=ASSERT, cnt=0, idx=0.
  - rst_o all ones; done_o=0; fault_o=0; retry_count_o=0; stage_o=0.
- All outputs are registered and change on the same edge as the state.
- reset_i has priority over every other event, including a coincident timeout or lost ready. On reset_i=1 the next state is ASSERT:
  - cnt=0, idx=0, rst_o all ones.
  - done_o=0, fault_o=0, retry_count_o=0.
  - ASSERT does not count while reset_i is held high.
- ASSERT:
  - rst_o all ones; cnt increments each cycle.
  - When cnt==HOLD-1: go to WAIT, idx=0, cnt=0, rst_o[0]<=0.
- WAIT:
  - rst_o[k]=0 for k<=idx, 1 otherwise.
  - If ready_i[idx]=1: go to GAP, cnt=0. Minimum one cycle in WAIT.
  - Else if cnt==TIMEOUT-1: timeout, retry_count+1.
    - If the new count equals MAX_RETRY: go to FAULT.
    - Otherwise go to ASSERT with cnt=0 and rst_o all ones.
  - Else cnt+1.
- GAP:
  - When cnt==GAP-1:
    - If idx==NUM_STAGES-1: go to DONE and set done_o=1.
    - Otherwise idx+1, go to WAIT, cnt=0, rst_o[idx+1]<=0.
  - Else cnt+1.
- Lost ready:
  - In GAP or DONE, if any ready_i[k]=0 with k<=idx, go to ASSERT.
  - done_o=0; retry_count is unchanged (not a timeout).
- DONE: holds while all ready_i are high.
- FAULT:
  - rst_o all ones, fault_o=1, done_o=0.
  - Exits only via reset_i or async reset.
- stage_o=idx, zero-extended.
- retry_count saturates at MAX_RETRY.
- Counters never wrap: each state exits at its terminal count.

Decomposition:
- Shared package/include:
  - state encoding ST_ASSERT, ST_WAIT, ST_GAP, ST_DONE, ST_FAULT;
  - a clog2 helper;
  - a RETRY_W=8 constant.
- One natural sub-module: rs_term_counter. It provides a clear, enable and terminal-value compare (cnt==limit-1). It is shared for the HOLD, GAP and TIMEOUT counts, with the limit muxed by state.

Test Plan:
Bench settings for all cases: NUM_STAGES=3, HOLD=4, GAP=2, TIMEOUT=8, MAX_RETRY=2. Edge numbers count rising edges after async_reset_i falls.
1. All ready_i=1 -> rst_o 111, then 110 at edge 4, 100 at edge 7, 000 at edge 10; done_o=1 at edge 13; stage_o steps 0,1,2.
2. ready_i[1]=0 -> first timeout at edge 15 (retry_count_o=1, rst_o=111). Sequence re-runs; second timeout -> FAULT with fault_o=1 and rst_o=111, held for 100 cycles. A one-cycle reset_i then clears fault_o and retry_count_o and restarts.
3. reset_i asserted for 3 cycles during stage-1 GAP -> rst_o=111 on the next edge and done_o=0; rst_o[0] falls 4 edges after reset_i is first sampled low.
4. In DONE, drop ready_i[0] for 1 cycle -> next edge ASSERT with rst_o=111 and done_o=0; retry_count_o unchanged; done_o returns 13 edges later.
5. reset_i=1 on the same cycle as the timeout terminal count -> ASSERT with retry_count_o=0 and fault_o=0 (reset_i wins).
6. async_reset_i pulsed mid-WAIT and in FAULT -> all outputs immediately return to reset values, without waiting for a clock edge.
